// File: rtl/pipe_pkg.sv
// Shared pipeline types: decoded control word, ALU op encodings and register constants.
package pipe_pkg;

    localparam int CTRL_ALUOP_W = 3;

    localparam logic [CTRL_ALUOP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [CTRL_ALUOP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [CTRL_ALUOP_W-1:0] ALU_AND = 3'd2;
    localparam logic [CTRL_ALUOP_W-1:0] ALU_OR  = 3'd3;
    localparam logic [CTRL_ALUOP_W-1:0] ALU_SLT = 3'd4;
    localparam logic [CTRL_ALUOP_W-1:0] ALU_FN  = 3'd7;

    typedef struct packed {
        logic                    RegWrite;
        logic                    MemRead;
        logic                    MemWrite;
        logic                    MemtoReg;
        logic                    ALUSrc;
        logic                    RegDst;
        logic                    Branch;
        logic [CTRL_ALUOP_W-1:0] ALUOp;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: EX-stage load whose destination feeds a source read by the ID instruction.
// Latency: purely combinational. Backpressure: none; the caller decides how to stall.
// Only sources the instruction really reads count, and $zero never creates a dependency.
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    output logic              hz
);

    logic ex_rt_nonzero;
    logic rs_match;
    logic rt_match;

    assign ex_rt_nonzero = (ex_rt != REG_AW'(REG_ZERO));
    assign rs_match      = id_uses_rs && (ex_rt == id_rs);
    assign rt_match      = id_uses_rt && (ex_rt == id_rt);

    assign hz = ex_valid && ex_mem_read && id_valid && ex_rt_nonzero && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion; optional perf counters via ID_EX_PERF_CNT_EN.
// Latency: 1 cycle ID->EX; a load followed by a dependent instruction costs exactly one bubble.
// Backpressure: mem_stall freezes everything; a hazard holds PC and IF/ID while a bubble enters EX.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  ctrl_t             id_ctrl,
    input  logic              flush,
    input  logic              mem_stall,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output ctrl_t             ex_ctrl,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]       perf_bubbles,
    output logic [31:0]       perf_flushes,
`endif
    output logic              load_use_stall
);

    // Opcodes wider than the configured ALU width are trimmed at capture.
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_MASK =
        CTRL_ALUOP_W'((64'd1 << ALUOP_W) - 64'd1);

    logic              valid_q,  valid_d;
    logic [REG_AW-1:0] rs_q,     rs_d;
    logic [REG_AW-1:0] rt_q,     rt_d;
    logic [REG_AW-1:0] rd_q,     rd_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic [DATA_W-1:0] imm_q,    imm_d;
    logic [DATA_W-1:0] pc4_q,    pc4_d;
    ctrl_t             ctrl_q,   ctrl_d;
    ctrl_t             id_ctrl_m;
    logic              hz;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.MemRead),
        .ex_rt       (rt_q),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .hz          (hz)
    );

    // A flush kills the ID instruction anyway, so it must not also freeze the front end.
    assign load_use_stall = hz && !flush;
    assign pc_write       = !mem_stall && !load_use_stall;
    assign if_id_write    = !mem_stall && !load_use_stall;

    always_comb begin
        id_ctrl_m       = id_ctrl;
        id_ctrl_m.ALUOp = id_ctrl.ALUOp & ALUOP_MASK;
    end

    always_comb begin
        valid_d  = valid_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        imm_d    = imm_q;
        pc4_d    = pc4_q;
        ctrl_d   = ctrl_q;
        if (mem_stall) begin
            valid_d = valid_q;
        end else if (flush || hz) begin
            valid_d  = 1'b0;
            rs_d     = '0;
            rt_d     = '0;
            rd_d     = '0;
            rdata1_d = '0;
            rdata2_d = '0;
            imm_d    = '0;
            pc4_d    = '0;
            ctrl_d   = CTRL_NOP;
        end else begin
            valid_d  = id_valid;
            rs_d     = id_rs;
            rt_d     = id_rt;
            rd_d     = id_rd;
            rdata1_d = id_rdata1;
            rdata2_d = id_rdata2;
            imm_d    = id_imm;
            pc4_d    = id_pc4;
            ctrl_d   = id_valid ? id_ctrl_m : CTRL_NOP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            pc4_q    <= '0;
            ctrl_q   <= CTRL_NOP;
        end else begin
            valid_q  <= valid_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            pc4_q    <= pc4_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign ex_valid  = valid_q;
    assign ex_rs     = rs_q;
    assign ex_rt     = rt_q;
    assign ex_rd     = rd_q;
    assign ex_rdata1 = rdata1_q;
    assign ex_rdata2 = rdata2_q;
    assign ex_imm    = imm_q;
    assign ex_pc4    = pc4_q;
    assign ex_ctrl   = ctrl_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubbles_q, bubbles_d;
    logic [31:0] flushes_q, flushes_d;
    logic        bubble_ev;
    logic        flush_ev;

    assign bubble_ev = !mem_stall && !flush && hz;
    assign flush_ev  = !mem_stall && flush;

    always_comb begin
        bubbles_d = bubbles_q;
        flushes_d = flushes_q;
        if (bubble_ev && (bubbles_q != '1)) begin
            bubbles_d = bubbles_q + 32'd1;
        end
        if (flush_ev && (flushes_q != '1)) begin
            flushes_d = flushes_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubbles_q <= '0;
            flushes_q <= '0;
        end else begin
            bubbles_q <= bubbles_d;
            flushes_q <= flushes_d;
        end
    end

    assign perf_bubbles = bubbles_q;
    assign perf_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use bubble, false-hazard filters, flush, mem_stall hold, async reset.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam ctrl_t LW_CTRL  = '{RegWrite: 1'b1, MemRead: 1'b1, MemWrite: 1'b0, MemtoReg: 1'b1,
                                   ALUSrc: 1'b1, RegDst: 1'b0, Branch: 1'b0, ALUOp: ALU_ADD};
    localparam ctrl_t ADD_CTRL = '{RegWrite: 1'b1, MemRead: 1'b0, MemWrite: 1'b0, MemtoReg: 1'b0,
                                   ALUSrc: 1'b0, RegDst: 1'b1, Branch: 1'b0, ALUOp: ALU_FN};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic              id_uses_rs, id_uses_rt;
    logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm, id_pc4;
    ctrl_t             id_ctrl;
    logic              flush, mem_stall;
    logic              pc_write, if_id_write, ex_valid, load_use_stall;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [DATA_W-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
    ctrl_t             ex_ctrl;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]       perf_bubbles, perf_flushes;
    logic [31:0]       pb_before, pf_before;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ALUOP_W(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .id_rdata1      (id_rdata1),
        .id_rdata2      (id_rdata2),
        .id_imm         (id_imm),
        .id_pc4         (id_pc4),
        .id_ctrl        (id_ctrl),
        .flush          (flush),
        .mem_stall      (mem_stall),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .ex_valid       (ex_valid),
        .ex_rs          (ex_rs),
        .ex_rt          (ex_rt),
        .ex_rd          (ex_rd),
        .ex_rdata1      (ex_rdata1),
        .ex_rdata2      (ex_rdata2),
        .ex_imm         (ex_imm),
        .ex_pc4         (ex_pc4),
        .ex_ctrl        (ex_ctrl),
`ifdef ID_EX_PERF_CNT_EN
        .perf_bubbles   (perf_bubbles),
        .perf_flushes   (perf_flushes),
`endif
        .load_use_stall (load_use_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic urs, input logic urt, input ctrl_t c);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_uses_rs = urs;
        id_uses_rt = urt;
        id_ctrl    = c;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        mem_stall = 1'b0;
        id_rdata1 = 32'h0;
        id_rdata2 = 32'h0;
        id_imm    = 32'h0;
        id_pc4    = 32'h0;
        drive(1'b1, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, LW_CTRL);

        // Reset held for three edges with random ID inputs.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, ctrl_t'($urandom));
            id_rdata1 = $urandom;
            id_imm    = $urandom;
            step();
            chk("rst_ex_valid", 32'(ex_valid), 32'd0);
            chk("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
            chk("rst_pc_write", 32'(pc_write), 32'd1);
            chk("rst_stall", 32'(load_use_stall), 32'd0);
        end
        chk("rst_ex_rdata1", ex_rdata1, 32'd0);
        rst_n = 1'b1;

        // lw $8, 4($29)
        drive(1'b1, 5'd29, 5'd8, 5'd0, 1'b1, 1'b0, LW_CTRL);
        id_rdata1 = 32'h1000;
        id_imm    = 32'h4;
        id_pc4    = 32'h104;
        #1;
        chk("post_rst_pc_write", 32'(pc_write), 32'd1);
        step();
        chk("lw_ex_valid", 32'(ex_valid), 32'd1);
        chk("lw_ex_rt", 32'(ex_rt), 32'd8);
        chk("lw_ex_ctrl", 32'(ex_ctrl), 32'(LW_CTRL));
        chk("lw_ex_pc4", ex_pc4, 32'h104);

        // add $9, $8, $10 -> one bubble
        drive(1'b1, 5'd8, 5'd10, 5'd9, 1'b1, 1'b1, ADD_CTRL);
        id_rdata1 = 32'hAAAA;
        id_rdata2 = 32'h5555;
        id_pc4    = 32'h108;
`ifdef ID_EX_PERF_CNT_EN
        pb_before = perf_bubbles;
`endif
        #1;
        chk("lu_stall", 32'(load_use_stall), 32'd1);
        chk("lu_pc_write", 32'(pc_write), 32'd0);
        chk("lu_if_id_write", 32'(if_id_write), 32'd0);
        step();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_ctrl", 32'(ex_ctrl), 32'd0);
        chk("lu_cleared_stall", 32'(load_use_stall), 32'd0);
        chk("lu_cleared_pc_write", 32'(pc_write), 32'd1);
`ifdef ID_EX_PERF_CNT_EN
        chk("perf_bubble_inc", perf_bubbles, pb_before + 32'd1);
`endif
        step();
        chk("add_ex_valid", 32'(ex_valid), 32'd1);
        chk("add_ex_rs", 32'(ex_rs), 32'd8);
        chk("add_ex_rd", 32'(ex_rd), 32'd9);
        chk("add_ex_rdata2", ex_rdata2, 32'h5555);

        // lw $0 followed by a reader of $0: no hazard
        drive(1'b1, 5'd29, 5'd0, 5'd0, 1'b1, 1'b0, LW_CTRL);
        step();
        drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, ADD_CTRL);
        #1;
        chk("zero_no_stall", 32'(load_use_stall), 32'd0);
        chk("zero_pc_write", 32'(pc_write), 32'd1);

        // lw $8 followed by an instruction that has rt=8 but does not read it
        drive(1'b1, 5'd29, 5'd8, 5'd0, 1'b1, 1'b0, LW_CTRL);
        step();
        drive(1'b1, 5'd3, 5'd8, 5'd0, 1'b1, 1'b0, LW_CTRL);
        #1;
        chk("unused_rt_no_stall", 32'(load_use_stall), 32'd0);
        step();
        chk("unused_rt_captured_valid", 32'(ex_valid), 32'd1);
        chk("unused_rt_captured_rs", 32'(ex_rs), 32'd3);

        // EX now holds lw $8; dependent instruction with flush
        drive(1'b1, 5'd8, 5'd2, 5'd4, 1'b1, 1'b1, ADD_CTRL);
        flush = 1'b1;
`ifdef ID_EX_PERF_CNT_EN
        pb_before = perf_bubbles;
        pf_before = perf_flushes;
`endif
        #1;
        chk("flush_no_stall", 32'(load_use_stall), 32'd0);
        chk("flush_pc_write", 32'(pc_write), 32'd1);
        step();
        flush = 1'b0;
        chk("flush_bubble_valid", 32'(ex_valid), 32'd0);
        chk("flush_bubble_ctrl", 32'(ex_ctrl), 32'd0);
        chk("flush_bubble_rs", 32'(ex_rs), 32'd0);
`ifdef ID_EX_PERF_CNT_EN
        chk("perf_flush_inc", perf_flushes, pf_before + 32'd1);
        chk("perf_flush_no_bubble", perf_bubbles, pb_before);
`endif

        // Capture rd=5 RegWrite, then freeze with mem_stall for 4 cycles
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, ADD_CTRL);
        id_rdata1 = 32'h11;
        step();
        chk("hold_setup_rd", 32'(ex_rd), 32'd5);
        mem_stall = 1'b1;
`ifdef ID_EX_PERF_CNT_EN
        pf_before = perf_flushes;
`endif
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, LW_CTRL);
            id_rdata1 = $urandom;
            flush     = (i % 2 == 1);
            #1;
            chk("hold_pc_write", 32'(pc_write), 32'd0);
            chk("hold_if_id_write", 32'(if_id_write), 32'd0);
            step();
            chk("hold_ex_rd", 32'(ex_rd), 32'd5);
            chk("hold_ex_valid", 32'(ex_valid), 32'd1);
            chk("hold_ex_ctrl", 32'(ex_ctrl), 32'(ADD_CTRL));
            chk("hold_ex_rdata1", ex_rdata1, 32'h11);
        end
`ifdef ID_EX_PERF_CNT_EN
        chk("perf_flush_frozen", perf_flushes, pf_before);
`endif
        mem_stall = 1'b0;
        flush     = 1'b0;

        // Invalid ID slot: control forced to NOP, fields still captured
        drive(1'b0, 5'd6, 5'd7, 5'd12, 1'b1, 1'b1, LW_CTRL);
        step();
        chk("inv_ex_valid", 32'(ex_valid), 32'd0);
        chk("inv_ex_ctrl", 32'(ex_ctrl), 32'd0);
        chk("inv_ex_rd", 32'(ex_rd), 32'd12);

        // Async reset during a hazard
        drive(1'b1, 5'd29, 5'd8, 5'd0, 1'b1, 1'b0, LW_CTRL);
        step();
        drive(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, ADD_CTRL);
        #1;
        chk("ar_stall_before", 32'(load_use_stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ex_valid", 32'(ex_valid), 32'd0);
        chk("ar_ex_ctrl", 32'(ex_ctrl), 32'd0);
        chk("ar_stall", 32'(load_use_stall), 32'd0);
        chk("ar_pc_write", 32'(pc_write), 32'd1);
        #1;
        rst_n = 1'b1;
        step();
        chk("ar_after_valid", 32'(ex_valid), 32'd1);
        chk("ar_after_rs", 32'(ex_rs), 32'd8);
        chk("ar_after_stall", 32'(load_use_stall), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
